fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch front end for the riscv core; sits between the instruction RAM and decode.
//  Drives word addresses to the synchronous-read IRAM, whose read data returns one cycle later.
//  Buffers fetched words in a small FIFO and hands {instruction, PC} to decode over a valid/ready handshake.
//  Accepts branch/jump redirects from execute and discards every wrong-path word.
// PARAMETERS
//  ADDR_W    8   width of the word-granular PC and of imem_addr (PC increments by 1 per instruction)
//  DEPTH     4   prefetch FIFO entries; power of 2, minimum 2
//  RESET_PC  0   PC loaded on reset
// PORTS
//  clock           in   1       rising-edge clock
//  clear           in   1       asynchronous reset, active-high
//  imem_req        out  1       IRAM read enable this cycle
//  imem_addr       out  ADDR_W  IRAM word address
//  imem_rdata      in   32      IRAM data, valid the cycle after imem_req
//  redirect_valid  in   1       one-cycle pulse: taken branch/jump
//  redirect_pc     in   ADDR_W  target word address
//  inst_valid      out  1       inst_data/inst_pc are valid
//  inst_ready      in   1       decode accepts this cycle
//  inst_data       out  32      instruction word
//  inst_pc         out  ADDR_W  word address of inst_data
// BEHAVIOUR
//  Reset (async, while clear=1):
//   - pc=RESET_PC, FIFO empty, in-flight flag cleared.
//   - imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
//   - First imem_req occurs in the first clock edge after clear falls.
//  Issue:
//   - imem_req=1 when (fifo_count + inflight) < DEPTH and no redirect is being applied.
//   - On issue, pc <= pc+1, modulo 2^ADDR_W; 0xFF wraps to 0x00.
//   - Sustains one request per cycle while there is space.
//  Return:
//   - Cycle after issue: imem_rdata is pushed together with the issued PC, unless the request was killed.
//   - Credit counting guarantees the FIFO never overflows. No request is dropped under backpressure.
//  Pop:
//   - inst_valid = FIFO not empty.
//   - Head entry leaves on inst_valid & inst_ready.
//   - Push and pop may occur in the same cycle, with the FIFO full or empty.
//  Redirect (redirect_valid=1 in cycle R):
//   - At the edge ending R: FIFO flushed, in-flight response marked killed, pc <= redirect_pc.
//   - No imem_req is issued in cycle R.
//   - Cycle R+1: imem_req=1, imem_addr=redirect_pc.
//   - A response arriving in R+1 from the pre-redirect request is discarded.
//   - Redirect wins over a simultaneous pop or push; the popped word still counts as consumed by decode.
//   - Back-to-back redirects: the last one wins.
//  Latency (macro off): issue in cycle N -> inst_valid in N+2 when the FIFO was empty; redirect-to-valid is 3 cycles.
//  Mid-operation reset: all state is discarded immediately, and the unit restarts at RESET_PC.
// CONFIGURATION
//  FETCH_BYPASS_EN
//   - Defined: when the FIFO is empty and a live response returns, the response drives inst_valid/inst_data/inst_pc combinationally in that same cycle.
//     - inst_ready=1: the response is not written to the FIFO.
//     - inst_ready=0: it is written.
//     - Latency becomes issue N -> inst_valid N+1; redirect-to-valid is 2 cycles.
//   - Undefined: all outputs come straight from FIFO registers, as described above.
//   - Credit and flush rules are identical in both builds.
// STRUCTURE
//  fetch_pkg:
//   - RISCV_NOP = 32'h00000013
//   - INST_W = 32
//   - fetch-entry typedef {pc[ADDR_W-1:0], inst[31:0]}
//  Sub-module fetch_fifo:
//   - DEPTH x entry, synchronous push/pop, count output, synchronous flush input.
//   - Read and write pointers wrap modulo DEPTH.
//  fetch_unit holds pc, the in-flight/killed flags, the issued-PC register, credit logic and the bypass mux.
// TESTING
//  - Reset, then inst_ready=1, IRAM[i]=i+0x100:
//    imem_addr 0,1,2... on consecutive cycles; inst_pc 0,1,2... with inst_data 0x100,0x101...
//    Macro off: first inst_valid 2 cycles after the first req. Macro on: 1 cycle after.
//  - inst_ready=0 for 10 cycles:
//    exactly DEPTH=4 requests issued, imem_req then held 0.
//    On release, PCs 0..3 pop in order, fetch resumes at 4 with no gap or duplicate.
//  - Redirect to 0x10 while one request is in flight and 2 entries are queued:
//    next accepted inst_pc=0x10; no PC from the old stream appears.
//  - Redirect in the same cycle as a pop with the FIFO full:
//    FIFO empty next cycle, count=0, imem_addr=redirect_pc.
//  - Redirect to 0xFE with inst_ready=1:
//    inst_pc sequence 0xFE, 0xFF, 0x00, 0x01.
//  - Assert clear mid-stream with 3 entries queued:
//    inst_valid drops immediately without waiting for a clock edge; after release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and entry layout for the instruction fetch front end.
// No logic; no latency.
// No flow control lives here.
package fetch_pkg;

   localparam int INST_W       = 32;
   localparam int FETCH_ADDR_W = 8;

   localparam logic [INST_W-1:0] RISCV_NOP = 32'h00000013;

   // One prefetch buffer entry: the word plus the word address it came from.
   typedef struct packed {
      logic [FETCH_ADDR_W-1:0] pc;
      logic [INST_W-1:0]       inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular FIFO with count output and synchronous flush.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: a push into a full FIFO is only taken when a pop frees the head the same cycle.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int WIDTH = FETCH_ADDR_W + INST_W,
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
)(
   input  logic             clock,
   input  logic             clear,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             wr_en;
   logic             rd_en;

   assign empty    = (count == '0);
   assign full     = (count == CNT_W'(DEPTH));
   assign pop_data = mem[rd_ptr];

   // Flush overrides both ports; pop on empty is ignored.
   always_comb begin
      wr_en = push & (~full | pop) & ~flush;
      rd_en = pop & ~empty & ~flush;
   end

   // Storage, pointers (wrap naturally since DEPTH is a power of 2) and occupancy.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues IRAM reads, buffers returned words, hands {inst, pc} to decode.
// Latency: issue N -> inst_valid N+2 (N+1 with FETCH_BYPASS_EN); redirect -> valid 3 cycles (2 with bypass).
// Backpressure: issue only while buffered + in-flight words < DEPTH, so no response is ever dropped.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
   input  logic              clock,
   input  logic              clear,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_data,
   output logic [ADDR_W-1:0] inst_pc
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] issued_pc;
   logic              inflight;
   logic              issue;
   logic              resp_live;
   logic              push;
   logic              pop;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    credits_used;
   entry_t            push_entry;
   entry_t            head_entry;

   assign imem_req  = issue;
   assign imem_addr = pc;

   // Credit check: every slot is reserved at issue time, so a returning word always has a home.
   // A response returning in a redirect cycle is killed here; nothing is issued in that cycle,
   // so the cycle after a redirect never carries a wrong-path word.
   always_comb begin
      credits_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight);
      issue        = ~clear & ~redirect_valid & (credits_used < (CNT_W+1)'(DEPTH));
      resp_live    = inflight & ~redirect_valid;
   end

   assign push_entry = '{pc: issued_pc, inst: imem_rdata};

`ifdef FETCH_BYPASS_EN
   logic bypass;

   // Empty buffer: a live response goes straight to decode and is only stored if decode stalls.
   always_comb begin
      bypass     = fifo_empty & resp_live;
      inst_valid = ~fifo_empty | bypass;
      inst_data  = bypass ? imem_rdata : head_entry.inst;
      inst_pc    = bypass ? issued_pc  : head_entry.pc;
      push       = resp_live & ~(bypass & inst_ready);
      pop        = ~fifo_empty & inst_ready;
   end
`else
   // Decode always sees the registered head of the buffer.
   always_comb begin
      inst_valid = ~fifo_empty;
      inst_data  = head_entry.inst;
      inst_pc    = head_entry.pc;
      push       = resp_live;
      pop        = ~fifo_empty & inst_ready;
   end
`endif

   // PC sequencing and tracking of the one outstanding IRAM read.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         pc        <= RESET_PC;
         issued_pc <= '0;
         inflight  <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) issued_pc <= pc;
         if (redirect_valid) pc <= redirect_pc;
         else if (issue)     pc <= pc + ADDR_W'(1);
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .clear     (clear),
      .flush     (redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head_entry),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

endmodule
